// File: rtl/fifo_pkg.sv
// Shared sizing constants for the scannable synchronous FIFO.
package fifo_pkg;
  localparam int DATA_W    = 17;
  localparam int ADDR_W    = 3;
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int CHAIN_LEN = 2 + 2 * ADDR_W + 2 * DATA_W;
endpackage

// File: rtl/fifo_scan_reg.sv
// Register with async active-low clear and a scan mux; in test mode it shifts
// toward bit 0, so bit 0 is the serial output.
module fifo_scan_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tm,
  input  logic         scan_in,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         scan_out
);

  logic [W-1:0] shifted;

  if (W == 1) begin : g_one
    assign shifted = scan_in;
  end else begin : g_multi
    assign shifted = {scan_in, q[W-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (tm) q <= shifted;
    else         q <= d;
  end

  assign scan_out = q[0];

endmodule

// File: rtl/fifo.sv
// Eight-entry FIFO with registered requests and a full scan chain over all
// flops except the storage array.
module fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W = fifo_pkg::DATA_W,
  parameter int ADDR_W = fifo_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_en,
  input  logic              r_en,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  input  logic              TM,
  input  logic              SI,
  output logic              SO
);

  logic              w_en_q, r_en_q;
  logic [ADDR_W-1:0] wptr, rptr, wptr_inc, rptr_inc, wptr_d, rptr_d;
  logic [DATA_W-1:0] din_q, dout_d;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic              do_write, do_read;
  logic              s_ren, s_wen, s_rptr, s_wptr, s_din;

  assign wptr_inc = wptr + 1'b1;
  assign rptr_inc = rptr + 1'b1;
  assign empty    = (wptr == rptr);
  assign full     = (wptr_inc == rptr);

  // One slot is sacrificed so that full and empty stay distinguishable.
  assign do_write = w_en_q && !full;
  assign do_read  = r_en_q && !empty;
  assign wptr_d   = do_write ? wptr_inc : wptr;
  assign rptr_d   = do_read  ? rptr_inc : rptr;
  assign dout_d   = do_read  ? mem[rptr] : data_out;

  always_ff @(posedge clk) begin
    if (!TM && do_write) mem[wptr] <= din_q;
  end

  // Chain: SI -> r_en_q -> w_en_q -> rptr -> wptr -> din_q -> data_out -> SO
  fifo_scan_reg #(.W(1)) u_ren (
    .clk(clk), .rst_n(rst_n), .tm(TM), .scan_in(SI),
    .d(r_en), .q(r_en_q), .scan_out(s_ren)
  );

  fifo_scan_reg #(.W(1)) u_wen (
    .clk(clk), .rst_n(rst_n), .tm(TM), .scan_in(s_ren),
    .d(w_en), .q(w_en_q), .scan_out(s_wen)
  );

  fifo_scan_reg #(.W(ADDR_W)) u_rptr (
    .clk(clk), .rst_n(rst_n), .tm(TM), .scan_in(s_wen),
    .d(rptr_d), .q(rptr), .scan_out(s_rptr)
  );

  fifo_scan_reg #(.W(ADDR_W)) u_wptr (
    .clk(clk), .rst_n(rst_n), .tm(TM), .scan_in(s_rptr),
    .d(wptr_d), .q(wptr), .scan_out(s_wptr)
  );

  fifo_scan_reg #(.W(DATA_W)) u_din (
    .clk(clk), .rst_n(rst_n), .tm(TM), .scan_in(s_wptr),
    .d(data_in), .q(din_q), .scan_out(s_din)
  );

  fifo_scan_reg #(.W(DATA_W)) u_dout (
    .clk(clk), .rst_n(rst_n), .tm(TM), .scan_in(s_din),
    .d(dout_d), .q(data_out), .scan_out(SO)
  );

endmodule

// File: tb/tb_fifo.sv
// Randomised scoreboard bench for fifo: a queue-based reference model predicts
// data_out/empty/full per edge, and a negedge monitor compares them.
module tb_fifo;

  localparam int DW  = 17;
  localparam int CAP = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          w_en = 1'b0, r_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          full, empty;
  logic          TM = 1'b0, SI = 1'b0;
  logic          SO;

  fifo dut (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .r_en(r_en),
    .data_in(data_in), .data_out(data_out), .full(full), .empty(empty),
    .TM(TM), .SI(SI), .SO(SO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] dout;
    logic          emp;
    logic          ful;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model_q[$];
  logic          pend_w, pend_r;
  logic [DW-1:0] pend_d;
  logic [DW-1:0] dout_m;
  int            n_cmp = 0;
  int            n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: requests presented at one edge act at the next edge; read and
  // write are each judged on the occupancy before the edge.
  task automatic model_edge(input logic w, input logic r, input logic [DW-1:0] d);
    int   sz;
    logic rd, wr;
    exp_t e;
    sz = model_q.size();
    rd = pend_r && (sz > 0);
    wr = pend_w && (sz < CAP);
    if (rd) dout_m = model_q.pop_front();
    if (wr) model_q.push_back(pend_d);
    pend_w = w;
    pend_r = r;
    pend_d = d;
    e.dout = dout_m;
    e.emp  = (model_q.size() == 0);
    e.ful  = (model_q.size() == CAP);
    exp_q.push_back(e);
  endtask

  task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
    w_en = w;
    r_en = r;
    data_in = d;
    @(posedge clk);
    model_edge(w, r, d);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("data_out", 32'(data_out), 32'(e.dout));
      check("empty", 32'(empty), 32'(e.emp));
      check("full", 32'(full), 32'(e.ful));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #1;
    w_en = 1'b0; r_en = 1'b0; data_in = '0; TM = 1'b0;
    rst_n = 1'b0;
    #2;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_SO", 32'(SO), 32'd0);
    model_q.delete();
    pend_w = 1'b0; pend_r = 1'b0; pend_d = '0; dout_m = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected under 200000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] captured;
    logic          bits[25];

    do_reset();

    // Fill with 0..6, then an extra write that must be dropped.
    for (int i = 0; i < CAP; i++) step(1'b1, 1'b0, DW'(i));
    step(1'b1, 1'b0, DW'(7));
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);

    // Drain past empty; data_out must hold the last word.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);

    // Alternate write/read so both pointers cross 7 -> 0.
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, DW'(100 + i));
      step(1'b0, 1'b1, '0);
    end
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);

    // Three entries, then simultaneous read/write for four cycles.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'(200 + i));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, DW'(300 + i));
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, '0);

    // Random traffic in write-heavy, read-heavy and balanced phases.
    for (int ph = 0; ph < 3; ph++) begin
      int pw, pr;
      pw = (ph == 0) ? 80 : (ph == 1) ? 20 : 50;
      pr = (ph == 0) ? 20 : (ph == 1) ? 80 : 50;
      for (int i = 0; i < 120; i++)
        step(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr), DW'($urandom));
    end

    // Reset with data still stored: contents must be discarded.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, DW'(400 + i));
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0);
    for (int i = 0; i < 60; i++)
      step(($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 50), DW'($urandom));

    // Scan: load 0..6, then shift in din_q=all ones, wptr=5, rptr=2, w_en_q=0, r_en_q=1.
    do_reset();
    for (int i = 0; i < CAP; i++) step(1'b1, 1'b0, DW'(i));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
    @(negedge clk);
    @(posedge clk);
    #1;
    for (int i = 0; i < 17; i++) bits[i] = 1'b1;
    bits[17] = 1'b1; bits[18] = 1'b0; bits[19] = 1'b1;
    bits[20] = 1'b0; bits[21] = 1'b1; bits[22] = 1'b0;
    bits[23] = 1'b0;
    bits[24] = 1'b1;
    TM = 1'b1;
    for (int i = 0; i < 25; i++) begin
      SI = bits[i];
      @(posedge clk);
      #1;
    end
    TM = 1'b0;
    SI = 1'b0;
    @(posedge clk);
    #1;
    check("capture_data_out", 32'(data_out), 32'd2);
    check("capture_empty", 32'(empty), 32'd0);
    check("capture_full", 32'(full), 32'd0);
    TM = 1'b1;
    for (int i = 0; i < DW; i++) begin
      captured[i] = SO;
      @(posedge clk);
      #1;
    end
    TM = 1'b0;
    check("scan_unload", 32'(captured), 32'd2);

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
